// File: rtl/vx_wb_arb_if.sv
// Writeback arbiter bus: NUM_INPUTS source channels in, one merged writeback channel out.
// The arbiter takes the master view; the environment takes the slave view.
interface vx_wb_arb_if #(
    parameter int NUM_INPUTS  = 4,
    parameter int UUID_BITS   = 8,
    parameter int NUM_THREADS = 2,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int XLEN        = 32
);
    localparam int SELW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int UUID_W = (UUID_BITS > 0) ? UUID_BITS : 1;
    localparam int NW_W   = (NW_BITS > 0) ? NW_BITS : 1;
    localparam int DATA_W = NUM_THREADS * XLEN;

    logic [NUM_INPUTS-1:0]                   in_valid;
    logic [NUM_INPUTS-1:0][UUID_W-1:0]       in_uuid;
    logic [NUM_INPUTS-1:0][NUM_THREADS-1:0]  in_tmask;
    logic [NUM_INPUTS-1:0][NW_W-1:0]         in_wid;
    logic [NUM_INPUTS-1:0][XLEN-1:0]         in_PC;
    logic [NUM_INPUTS-1:0][NR_BITS-1:0]      in_rd;
    logic [NUM_INPUTS-1:0][DATA_W-1:0]       in_data;
    logic [NUM_INPUTS-1:0]                   in_eop;
    logic [NUM_INPUTS-1:0]                   in_ready;

    logic                                    out_valid;
    logic [UUID_W-1:0]                       out_uuid;
    logic [NUM_THREADS-1:0]                  out_tmask;
    logic [NW_W-1:0]                         out_wid;
    logic [XLEN-1:0]                         out_PC;
    logic [NR_BITS-1:0]                      out_rd;
    logic [DATA_W-1:0]                       out_data;
    logic                                    out_eop;
    logic                                    out_ready;
    logic [SELW-1:0]                         out_sel;

    modport master (
        input  in_valid, in_uuid, in_tmask, in_wid, in_PC, in_rd, in_data, in_eop,
        output in_ready,
        output out_valid, out_uuid, out_tmask, out_wid, out_PC, out_rd, out_data, out_eop,
        input  out_ready,
        output out_sel
    );

    modport slave (
        output in_valid, in_uuid, in_tmask, in_wid, in_PC, in_rd, in_data, in_eop,
        input  in_ready,
        input  out_valid, out_uuid, out_tmask, out_wid, out_PC, out_rd, out_data, out_eop,
        output out_ready,
        input  out_sel
    );
endinterface

// File: rtl/vx_wb_arb.sv
// Round-robin writeback arbiter with optional eop packet locking and an
// optional two-entry skid buffer on the merged output.
module vx_wb_arb #(
    parameter int NUM_INPUTS  = 4,
    parameter int LOCK_EOP    = 1,
    parameter int OUT_BUF     = 2,
    parameter int UUID_BITS   = 8,
    parameter int NUM_THREADS = 2,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int XLEN        = 32
) (
    input  logic        clk,
    input  logic        reset,
    vx_wb_arb_if.master bus
);
    localparam int SELW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int UUID_W = (UUID_BITS > 0) ? UUID_BITS : 1;
    localparam int NW_W   = (NW_BITS > 0) ? NW_BITS : 1;
    localparam int DATA_W = NUM_THREADS * XLEN;
    localparam int PAYW   = UUID_W + NUM_THREADS + NW_W + XLEN + NR_BITS + DATA_W + 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                state, state_n;
    logic [SELW-1:0]       lock_idx, lock_idx_n;
    logic [SELW-1:0]       rr_ptr, rr_ptr_n;
    logic [SELW-1:0]       grant_idx;
    logic                  grant_vld;
    logic [NUM_INPUTS-1:0] grant;
    logic                  stage_can_accept;
    logic                  fire;
    logic                  sel_eop;
    logic [PAYW-1:0]       sel_pay;

    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] i);
        if (int'(i) + 1 >= NUM_INPUTS)
            next_idx = '0;
        else
            next_idx = SELW'(int'(i) + 1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_n;
            lock_idx <= lock_idx_n;
            rr_ptr   <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n    = state;
        lock_idx_n = lock_idx;
        rr_ptr_n   = rr_ptr;
        if (fire) begin
            if (sel_eop || (LOCK_EOP == 0))
                rr_ptr_n = next_idx(grant_idx);
            if (LOCK_EOP != 0) begin
                if ((state == IDLE) && !sel_eop) begin
                    state_n    = LOCKED;
                    lock_idx_n = grant_idx;
                end else if ((state == LOCKED) && sel_eop) begin
                    state_n = IDLE;
                end
            end
        end
    end

    // Grant: fixed to the locked channel, otherwise first valid channel from rr_ptr upward.
    always_comb begin
        int              j;
        logic [SELW-1:0] idx;
        j         = 0;
        idx       = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (state == LOCKED) begin
            grant_idx = lock_idx;
            grant_vld = bus.in_valid[lock_idx];
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_INPUTS)
                    j = j - NUM_INPUTS;
                idx = SELW'(j);
                if (bus.in_valid[idx]) begin
                    grant_idx = idx;
                    grant_vld = 1'b1;
                end
            end
        end
        grant            = '0;
        grant[grant_idx] = grant_vld;
    end

    assign sel_pay = {bus.in_uuid[grant_idx], bus.in_tmask[grant_idx], bus.in_wid[grant_idx],
                      bus.in_PC[grant_idx], bus.in_rd[grant_idx], bus.in_data[grant_idx],
                      bus.in_eop[grant_idx]};
    assign sel_eop      = bus.in_eop[grant_idx];
    assign fire         = grant_vld & stage_can_accept;
    assign bus.in_ready = grant & {NUM_INPUTS{stage_can_accept}};

    if (OUT_BUF == 0) begin : g_pass
        assign stage_can_accept = bus.out_ready & ~reset;
        assign bus.out_valid    = grant_vld & ~reset;
        assign bus.out_sel      = reset ? '0 : grant_idx;
        assign {bus.out_uuid, bus.out_tmask, bus.out_wid, bus.out_PC,
                bus.out_rd, bus.out_data, bus.out_eop} = sel_pay;
    end else begin : g_skid
        logic            vld_p0, vld_p1;
        logic [SELW-1:0] sel_p0, sel_p1;
        logic [PAYW-1:0] pay_p0, pay_p1;
        logic            head_free;

        // p0 is the head driving the output, p1 the skid entry; in_ready depends only on p1.
        assign head_free        = bus.out_ready | ~vld_p0;
        assign stage_can_accept = ~vld_p1 & ~reset;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                sel_p0 <= '0;
                sel_p1 <= '0;
            end else if (head_free) begin
                if (vld_p1) begin
                    vld_p0 <= 1'b1;
                    sel_p0 <= sel_p1;
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p0 <= fire;
                    if (fire)
                        sel_p0 <= grant_idx;
                end
            end else if (fire) begin
                vld_p1 <= 1'b1;
                sel_p1 <= grant_idx;
            end
        end

        always_ff @(posedge clk) begin
            if (head_free) begin
                if (vld_p1)
                    pay_p0 <= pay_p1;
                else if (fire)
                    pay_p0 <= sel_pay;
            end else if (fire) begin
                pay_p1 <= sel_pay;
            end
        end

        assign bus.out_valid = vld_p0;
        assign bus.out_sel   = sel_p0;
        assign {bus.out_uuid, bus.out_tmask, bus.out_wid, bus.out_PC,
                bus.out_rd, bus.out_data, bus.out_eop} = pay_p0;
    end
endmodule

// File: tb/tb_vx_wb_arb.sv
// Bench for vx_wb_arb: directed vectors on 4-input, 1-input pass-through
// and 3-input instances, plus a scoreboarded random stream on the 3-input one.
module tb_vx_wb_arb;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    int unsigned seq_in  [3];
    int unsigned seq_out [3];
    bit          eop_hist [3][16384];
    logic        eop_cur [3];
    int          och;
    int unsigned oseq;
    int          last_ch;
    logic        last_open;
    logic [1:0]  ch;
    logic [3:0]  rdy_pat;

    always #5 clk = ~clk;

    vx_wb_arb_if #(.NUM_INPUTS(4)) bus_a ();
    vx_wb_arb_if #(.NUM_INPUTS(1)) bus_b ();
    vx_wb_arb_if #(.NUM_INPUTS(3)) bus_c ();

    vx_wb_arb #(.NUM_INPUTS(4), .LOCK_EOP(1), .OUT_BUF(2)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    vx_wb_arb #(.NUM_INPUTS(1), .LOCK_EOP(1), .OUT_BUF(0)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    vx_wb_arb #(.NUM_INPUTS(3), .LOCK_EOP(1), .OUT_BUF(2)) u_dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv_a(input logic [1:0] c, input logic v, input logic eop, input logic [63:0] d);
        bus_a.in_valid[c] = v;
        bus_a.in_eop[c]   = eop;
        bus_a.in_data[c]  = d;
        bus_a.in_uuid[c]  = d[7:0];
        bus_a.in_PC[c]    = d[31:0];
    endtask

    task automatic init_inputs();
        bus_a.in_valid = '0; bus_a.in_eop = '0; bus_a.in_data = '0; bus_a.in_uuid = '0;
        bus_a.in_tmask = '0; bus_a.in_wid = '0; bus_a.in_PC = '0; bus_a.in_rd = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid = '0; bus_b.in_eop = '0; bus_b.in_data = '0; bus_b.in_uuid = '0;
        bus_b.in_tmask = '0; bus_b.in_wid = '0; bus_b.in_PC = '0; bus_b.in_rd = '0;
        bus_b.out_ready = 1'b1;
        bus_c.in_valid = '0; bus_c.in_eop = '0; bus_c.in_data = '0; bus_c.in_uuid = '0;
        bus_c.in_tmask = '0; bus_c.in_wid = '0; bus_c.in_PC = '0; bus_c.in_rd = '0;
        bus_c.out_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_inputs();
        // Reset state, with all channels requesting during reset
        for (int i = 0; i < 4; i++) drv_a(2'(i), 1'b1, 1'b1, 64'hA0 + 64'(i));
        cyc();
        cyc();
        #1;
        check_eq("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check_eq("rst_out_sel", 64'(bus_a.out_sel), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("fair_first_rdy", 64'(bus_a.in_ready), 64'b0001);

        // Fairness: all valid, eop=1, out_ready=1
        for (int n = 1; n <= 8; n++) begin
            cyc();
            check_eq("fair_vld", 64'(bus_a.out_valid), 64'd1);
            check_eq("fair_sel", 64'(bus_a.out_sel), 64'((n - 1) % 4));
            check_eq("fair_data", bus_a.out_data, 64'hA0 + 64'((n - 1) % 4));
            check_eq("fair_rdy", 64'(bus_a.in_ready), 64'd1 << (n % 4));
        end
        check_eq("fair_uuid", 64'(bus_a.out_uuid), 64'hA3);
        check_eq("fair_pc", 64'(bus_a.out_PC), 64'hA3);
        for (int i = 0; i < 4; i++) drv_a(2'(i), 1'b0, 1'b0, 64'd0);
        cyc();
        check_eq("fair_drain", 64'(bus_a.out_valid), 64'd0);

        // Lock: move rr_ptr to 2 with a ch1 beat, then ch2 packet of 3 beats vs ch0/ch1
        drv_a(2'd1, 1'b1, 1'b1, 64'h11);
        #1;
        check_eq("lk_pre_rdy", 64'(bus_a.in_ready), 64'b0010);
        cyc();
        drv_a(2'd0, 1'b1, 1'b1, 64'h100);
        drv_a(2'd1, 1'b1, 1'b1, 64'h110);
        drv_a(2'd2, 1'b1, 1'b0, 64'h200);
        #1;
        check_eq("lk_pre_sel", 64'(bus_a.out_sel), 64'd1);
        check_eq("lk_pre_data", bus_a.out_data, 64'h11);
        check_eq("lk_rr2_rdy", 64'(bus_a.in_ready), 64'b0100);
        cyc();
        drv_a(2'd2, 1'b0, 1'b0, 64'h201);
        #1;
        check_eq("lk_b0_sel", 64'(bus_a.out_sel), 64'd2);
        check_eq("lk_b0_data", bus_a.out_data, 64'h200);
        check_eq("lk_hold_rdy", 64'(bus_a.in_ready), 64'b0000);
        cyc();
        check_eq("lk_gap_vld", 64'(bus_a.out_valid), 64'd0);
        drv_a(2'd2, 1'b1, 1'b0, 64'h201);
        #1;
        check_eq("lk_b1_rdy", 64'(bus_a.in_ready), 64'b0100);
        cyc();
        check_eq("lk_b1_sel", 64'(bus_a.out_sel), 64'd2);
        check_eq("lk_b1_data", bus_a.out_data, 64'h201);
        drv_a(2'd2, 1'b1, 1'b1, 64'h202);
        #1;
        check_eq("lk_b2_rdy", 64'(bus_a.in_ready), 64'b0100);
        cyc();
        check_eq("lk_b2_sel", 64'(bus_a.out_sel), 64'd2);
        check_eq("lk_b2_data", bus_a.out_data, 64'h202);
        check_eq("lk_b2_eop", 64'(bus_a.out_eop), 64'd1);
        drv_a(2'd2, 1'b0, 1'b0, 64'd0);
        #1;
        check_eq("lk_wrap_rdy", 64'(bus_a.in_ready), 64'b0001);
        cyc();
        check_eq("lk_wrap_sel", 64'(bus_a.out_sel), 64'd0);
        check_eq("lk_wrap_data", bus_a.out_data, 64'h100);
        for (int i = 0; i < 4; i++) drv_a(2'(i), 1'b0, 1'b0, 64'd0);
        cyc();
        check_eq("lk_drain", 64'(bus_a.out_valid), 64'd0);

        // Backpressure: out_ready low for 5 edges while ch1 streams
        bus_a.out_ready = 1'b0;
        drv_a(2'd1, 1'b1, 1'b1, 64'h300);
        #1;
        check_eq("bp_rdy1", 64'(bus_a.in_ready), 64'b0010);
        cyc();
        check_eq("bp_vld1", 64'(bus_a.out_valid), 64'd1);
        check_eq("bp_data1", bus_a.out_data, 64'h300);
        drv_a(2'd1, 1'b1, 1'b1, 64'h301);
        #1;
        check_eq("bp_rdy2", 64'(bus_a.in_ready), 64'b0010);
        cyc();
        drv_a(2'd1, 1'b1, 1'b1, 64'h302);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("bp_refuse", 64'(bus_a.in_ready), 64'b0000);
            check_eq("bp_hold_vld", 64'(bus_a.out_valid), 64'd1);
            check_eq("bp_hold_data", bus_a.out_data, 64'h300);
            check_eq("bp_hold_sel", 64'(bus_a.out_sel), 64'd1);
            cyc();
        end
        bus_a.out_ready = 1'b1;
        #1;
        check_eq("bp_reg_rdy", 64'(bus_a.in_ready), 64'b0000);
        cyc();
        check_eq("bp_rel_data1", bus_a.out_data, 64'h301);
        check_eq("bp_rel_rdy", 64'(bus_a.in_ready), 64'b0010);
        cyc();
        check_eq("bp_rel_vld2", 64'(bus_a.out_valid), 64'd1);
        check_eq("bp_rel_data2", bus_a.out_data, 64'h302);
        drv_a(2'd1, 1'b0, 1'b0, 64'd0);
        cyc();
        check_eq("bp_drain", 64'(bus_a.out_valid), 64'd0);

        // Reset mid-lock: ch3 opens a packet, then reset
        drv_a(2'd3, 1'b1, 1'b0, 64'h400);
        #1;
        check_eq("rml_rdy3", 64'(bus_a.in_ready), 64'b1000);
        cyc();
        drv_a(2'd3, 1'b0, 1'b0, 64'd0);
        drv_a(2'd0, 1'b1, 1'b1, 64'h500);
        #1;
        check_eq("rml_locked", 64'(bus_a.in_ready), 64'b0000);
        check_eq("rml_sel3", 64'(bus_a.out_sel), 64'd3);
        reset = 1'b1;
        #1;
        check_eq("rml_rst_rdy", 64'(bus_a.in_ready), 64'd0);
        cyc();
        reset = 1'b0;
        check_eq("rml_vld", 64'(bus_a.out_valid), 64'd0);
        check_eq("rml_sel", 64'(bus_a.out_sel), 64'd0);
        #1;
        check_eq("rml_idle_rdy", 64'(bus_a.in_ready), 64'b0001);
        cyc();
        check_eq("rml_next_sel", 64'(bus_a.out_sel), 64'd0);
        check_eq("rml_next_data", bus_a.out_data, 64'h500);
        drv_a(2'd0, 1'b0, 1'b0, 64'd0);
        cyc();

        // Single input, combinational pass-through
        rdy_pat = 4'b1101;
        bus_b.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_b.in_data[0] = 64'hB000 + 64'(k);
            bus_b.in_eop[0]  = k[0];
            bus_b.out_ready  = rdy_pat[k];
            #1;
            check_eq("pt_vld", 64'(bus_b.out_valid), 64'd1);
            check_eq("pt_data", bus_b.out_data, 64'hB000 + 64'(k));
            check_eq("pt_eop", 64'(bus_b.out_eop), 64'(k[0]));
            check_eq("pt_rdy", 64'(bus_b.in_ready), 64'(rdy_pat[k]));
            check_eq("pt_sel", 64'(bus_b.out_sel), 64'd0);
            cyc();
        end
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b1;
        #1;
        check_eq("pt_idle_vld", 64'(bus_b.out_valid), 64'd0);
        check_eq("pt_idle_rdy", 64'(bus_b.in_ready), 64'd0);

        // Random stream on 3 inputs with a per-channel scoreboard
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seq_in[i]  = 0;
            seq_out[i] = 0;
            eop_cur[i] = 1'($urandom_range(0, 1));
        end
        last_open = 1'b0;
        last_ch   = 0;
        for (int n = 0; n < 10010; n++) begin
            for (int i = 0; i < 3; i++) begin
                ch = 2'(i);
                bus_c.in_valid[ch] = (n < 10000) && ($urandom_range(0, 3) != 0);
                bus_c.in_eop[ch]   = eop_cur[i];
                bus_c.in_data[ch]  = {32'(i), 32'(seq_in[i])};
            end
            bus_c.out_ready = (n >= 10000) || ($urandom_range(0, 3) != 0);
            #1;
            check_eq("rnd_onehot", 64'($onehot0(bus_c.in_ready)), 64'd1);
            check_eq("rnd_rdy_vld", 64'(bus_c.in_ready & ~bus_c.in_valid), 64'd0);
            for (int i = 0; i < 3; i++) begin
                ch = 2'(i);
                if (bus_c.in_valid[ch] && bus_c.in_ready[ch]) begin
                    eop_hist[i][seq_in[i]] = eop_cur[i];
                    seq_in[i]++;
                    eop_cur[i] = 1'($urandom_range(0, 1));
                end
            end
            if (bus_c.out_valid && bus_c.out_ready) begin
                och  = int'(bus_c.out_data[33:32]);
                oseq = bus_c.out_data[31:0];
                check_eq("rnd_sel", 64'(bus_c.out_sel), 64'(och));
                if (och < 3) begin
                    check_eq("rnd_order", 64'(oseq), 64'(seq_out[och]));
                    check_eq("rnd_eop", 64'(bus_c.out_eop), 64'(eop_hist[och][seq_out[och]]));
                    seq_out[och]++;
                end else begin
                    check_eq("rnd_chan", 64'(och), 64'd0);
                end
                if (last_open)
                    check_eq("rnd_contig", 64'(och), 64'(last_ch));
                last_open = ~bus_c.out_eop;
                last_ch   = och;
            end
            cyc();
        end
        for (int i = 0; i < 3; i++)
            check_eq("rnd_count", 64'(seq_out[i]), 64'(seq_in[i]));
        check_eq("rnd_end_vld", 64'(bus_c.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
